// File: rtl/correlator_mc.sv
// correlator_mc: two-channel bit correlator that counts X, Y, X&Y and X^Y over
// 2^L samples and streams a 7-byte report packet per window over valid/ready.
module correlator_mc #(
  parameter int N_CH = 8,
  parameter int MAX_WINDOW_LENGTH_EXP = 16,
  parameter int MAX_SAMPLE_PERIOD_EXP = 15,
  localparam int LW = $clog2(MAX_WINDOW_LENGTH_EXP + 1),
  localparam int PW = $clog2(MAX_SAMPLE_PERIOD_EXP + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_cg,
  input  logic [N_CH-1:0] i_ch,
  input  logic [3:0]      i_selX,
  input  logic [3:0]      i_selY,
  input  logic [LW-1:0]   i_windowLengthExp,
  input  logic [PW-1:0]   i_samplePeriodExp,
  input  logic            i_cfgLoad,
  input  logic            i_run,
  output logic [7:0]      o_pkt_data,
  output logic            o_pkt_valid,
  input  logic            i_pkt_ready,
  output logic            o_running
);
  localparam int CW = MAX_WINDOW_LENGTH_EXP + 1;
  localparam int TW = MAX_WINDOW_LENGTH_EXP;
  localparam int SW = MAX_SAMPLE_PERIOD_EXP;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q;
  logic [3:0]      sel_x_q, sel_y_q;
  logic [LW-1:0]   l_q;
  logic [PW-1:0]   p_q;
  logic [SW-1:0]   per_q;
  logic [TW-1:0]   t_q;
  logic [CW-1:0]   cx_q, cy_q, ci_q, cs_q;
  logic [CW-1:0]   cx_d, cy_d, ci_d, cs_d;
  logic [7:0]      win_q, drop_q;
  logic [55:0]     pkt_q;
  logic [2:0]      idx_q;
  logic            valid_q;
  logic [15:0]     ch_ext;
  logic            x, y, strobe, win_end, xfer, last, free;
  logic [SW-1:0]   pmask;
  logic [TW-1:0]   tmask;

  // Scale a count to 8 bits relative to the window length, saturating at 255.
  function automatic logic [7:0] rep(input logic [CW-1:0] c, input logic [LW-1:0] l);
    logic [CW+7:0] f;
    f = {c, 8'h00} >> l;
    return (|f[CW+7:8]) ? 8'hFF : f[7:0];
  endfunction

  // Zero-extending the channel vector makes out-of-range selects read as 0.
  assign ch_ext  = 16'(i_ch);
  assign x       = ch_ext[sel_x_q];
  assign y       = ch_ext[sel_y_q];
  assign pmask   = ~({SW{1'b1}} << p_q);
  assign tmask   = ~({TW{1'b1}} << l_q);
  assign strobe  = i_cg && !i_cfgLoad && (state_q == RUN) && (per_q == pmask);
  assign win_end = strobe && (t_q == tmask);
  assign xfer    = i_cg && valid_q && i_pkt_ready;
  assign last    = xfer && (idx_q == 3'd6);
  assign free    = !valid_q || last;

  always_comb begin
    cx_d = cx_q + CW'(x);
    cy_d = cy_q + CW'(y);
    ci_d = ci_q + CW'(x & y);
    cs_d = cs_q + CW'(x ^ y);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      sel_x_q <= '0;
      sel_y_q <= '0;
      l_q     <= '0;
      p_q     <= '0;
      per_q   <= '0;
      t_q     <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      ci_q    <= '0;
      cs_q    <= '0;
      win_q   <= '0;
      drop_q  <= '0;
      pkt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (i_cg) begin
      if (i_cfgLoad) begin
        state_q <= i_run ? RUN : IDLE;
        sel_x_q <= i_selX;
        sel_y_q <= i_selY;
        l_q     <= i_windowLengthExp;
        p_q     <= i_samplePeriodExp;
        per_q   <= '0;
        t_q     <= '0;
        cx_q    <= '0;
        cy_q    <= '0;
        ci_q    <= '0;
        cs_q    <= '0;
      end else if (state_q == RUN) begin
        per_q <= strobe ? '0 : per_q + 1'b1;
        if (strobe) begin
          t_q  <= win_end ? '0 : t_q + 1'b1;
          cx_q <= win_end ? '0 : cx_d;
          cy_q <= win_end ? '0 : cy_d;
          ci_q <= win_end ? '0 : ci_d;
          cs_q <= win_end ? '0 : cs_d;
        end
      end
      if (win_end) win_q <= win_q + 1'b1;
      if (win_end && !free && drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
      if (win_end && free) begin
        pkt_q   <= {rep(cs_d, l_q), rep(ci_d, l_q), rep(cy_d, l_q), rep(cx_d, l_q),
                    sel_y_q, sel_x_q, drop_q, win_q};
        idx_q   <= '0;
        valid_q <= 1'b1;
      end else if (xfer) begin
        pkt_q   <= pkt_q >> 8;
        idx_q   <= last ? 3'd0 : idx_q + 1'b1;
        valid_q <= !last;
      end
    end
  end

  assign o_pkt_data  = pkt_q[7:0];
  assign o_pkt_valid = valid_q;
  assign o_running   = (state_q == RUN);
endmodule
